// File: rtl/int_alu_stage.sv
// Integer ALU execute stage: RV32I ALU feeding a 2-entry in-order result queue
// that drives one CDB lane through a valid/ready handshake.
module int_alu_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned PRF_IDX  = 6,
  parameter int unsigned ARCH_IDX = 5,
  parameter int unsigned ROB_IDX  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,

  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_fu_opcode,
  input  logic [1:0]          in_op1_sel,
  input  logic [1:0]          in_op2_sel,
  input  logic [XLEN-1:0]     in_rs1_value,
  input  logic [XLEN-1:0]     in_rs2_value,
  input  logic [XLEN-1:0]     in_imm,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [PRF_IDX-1:0]  in_rd_phy,
  input  logic [ARCH_IDX-1:0] in_rd_arch,
  input  logic [ROB_IDX-1:0]  in_rob_id,

  output logic                cdb_valid,
  input  logic                cdb_ready,
  output logic [ROB_IDX-1:0]  cdb_rob_id,
  output logic [PRF_IDX-1:0]  cdb_rd_phy,
  output logic [ARCH_IDX-1:0] cdb_rd_arch,
  output logic [XLEN-1:0]     cdb_rd_value
);

  localparam int unsigned ShW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpSll  = 4'd2,
    OpSlt  = 4'd3,
    OpSltu = 4'd4,
    OpXor  = 4'd5,
    OpSrl  = 4'd6,
    OpSra  = 4'd7,
    OpOr   = 4'd8,
    OpAnd  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    Op1Rs1  = 2'd0,
    Op1Pc   = 2'd1,
    Op1Zero = 2'd2
  } op1_sel_e;

  typedef enum logic [1:0] {
    Op2Rs2  = 2'd0,
    Op2Imm  = 2'd1,
    Op2Zero = 2'd2
  } op2_sel_e;

  typedef struct packed {
    logic [ROB_IDX-1:0]  rob_id;
    logic [PRF_IDX-1:0]  rd_phy;
    logic [ARCH_IDX-1:0] rd_arch;
    logic [XLEN-1:0]     value;
  } entry_t;

  // Operand selection and ALU
  logic [XLEN-1:0] op1, op2, alu_res;
  logic [ShW-1:0]  shamt;

  always_comb begin
    unique case (op1_sel_e'(in_op1_sel))
      Op1Rs1:  op1 = in_rs1_value;
      Op1Pc:   op1 = in_pc;
      default: op1 = '0;
    endcase
  end

  always_comb begin
    unique case (op2_sel_e'(in_op2_sel))
      Op2Rs2:  op2 = in_rs2_value;
      Op2Imm:  op2 = in_imm;
      default: op2 = '0;
    endcase
  end

  assign shamt = op2[ShW-1:0];

  always_comb begin
    alu_res = '0;
    case (alu_op_e'(in_fu_opcode))
      OpAdd:   alu_res = op1 + op2;
      OpSub:   alu_res = op1 - op2;
      OpSll:   alu_res = op1 << shamt;
      OpSlt:   alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      OpSltu:  alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
      OpXor:   alu_res = op1 ^ op2;
      OpSrl:   alu_res = op1 >> shamt;
      OpSra:   alu_res = XLEN'($signed(op1) >>> shamt);
      OpOr:    alu_res = op1 | op2;
      OpAnd:   alu_res = op1 & op2;
      // Undefined opcodes complete with a zero result rather than stalling.
      default: alu_res = '0;
    endcase
  end

  entry_t new_entry;

  always_comb begin
    new_entry.rob_id  = in_rob_id;
    new_entry.rd_phy  = in_rd_phy;
    new_entry.rd_arch = in_rd_arch;
    // x0 writes still broadcast so the ROB can retire them.
    new_entry.value   = (in_rd_arch == '0) ? '0 : alu_res;
  end

  // Result queue
  entry_t     queue_q [2];
  logic       head_q, tail_q;
  logic [1:0] count_q;
  logic       push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign cdb_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = cdb_valid && cdb_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      count_q    <= 2'd0;
      queue_q[0] <= '0;
      queue_q[1] <= '0;
    end else if (flush) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        queue_q[tail_q] <= new_entry;
        tail_q          <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Data outputs read as zero whenever nothing is being broadcast.
  entry_t head_entry;

  always_comb begin
    head_entry = cdb_valid ? queue_q[head_q] : '0;
  end

  assign cdb_rob_id   = head_entry.rob_id;
  assign cdb_rd_phy   = head_entry.rd_phy;
  assign cdb_rd_arch  = head_entry.rd_arch;
  assign cdb_rd_value = head_entry.value;

endmodule
